// File: rtl/fp32_uart_pkg.sv
// Shared types and constants for the fp32 host-link UART blocks.
// FP32_WORDS packed fp32 values make up one UART_NUM_BYTES-byte word.
package fp32_uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    localparam int DEFAULT_CLKS_PER_BIT = 5208;
    localparam int FP32_WORDS           = 3;
    localparam int UART_NUM_BYTES       = FP32_WORDS * 4;

endpackage

// File: rtl/fp32_uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and strobes bit_end on the last cycle.
// clear holds the count at zero so the first period after release is a full one.
module fp32_uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic CLK_I,
    input  logic RST_I,
    input  logic clear,
    output logic bit_end
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] clk_cnt_reg;

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            clk_cnt_reg <= '0;
        end else if (clear || bit_end) begin
            clk_cnt_reg <= '0;
        end else begin
            clk_cnt_reg <= clk_cnt_reg + 1'b1;
        end
    end

    assign bit_end = !clear && (clk_cnt_reg == CNT_LAST);

endmodule

// File: rtl/fp32_uart_tx_96.sv
// 96-bit word UART transmitter: 12 bytes, byte 0 first, each start + 8 data (LSB first) + stop bits.
// Every output is registered from the next-state values so the line never glitches.
module fp32_uart_tx_96
    import fp32_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int NUM_BYTES    = UART_NUM_BYTES,
    parameter int STOP_BITS    = 2
) (
    input  logic                   CLK_I,
    input  logic                   RST_I,
    input  logic                   TX_VALID_I,
    output logic                   TX_READY_O,
    input  logic [NUM_BYTES*8-1:0] TX_DATA_I,
    output logic                   UART_TX_O,
    output logic                   TX_BUSY_O,
    output logic                   TX_DONE_O
);

    localparam int BW  = $clog2(NUM_BYTES);
    localparam int SCW = $clog2(STOP_BITS + 1);
    localparam logic [BW-1:0]  BYTE_LAST = BW'(NUM_BYTES - 1);
    localparam logic [SCW-1:0] STOP_LAST = SCW'(STOP_BITS - 1);

    tx_state_t state_reg, state_next;
    logic [2:0]             bit_idx_reg, bit_idx_next;
    logic [BW-1:0]          byte_idx_reg, byte_idx_next;
    logic [SCW-1:0]         stop_cnt_reg, stop_cnt_next;
    logic [NUM_BYTES*8-1:0] data_reg;

    logic line_reg, line_next;
    logic ready_reg, ready_next;
    logic busy_reg, busy_next;
    logic done_reg, done_next;

    logic accept;
    logic bit_end;
    logic frame_end;
    logic [BW+2:0] bit_sel;

    assign accept = TX_VALID_I && ready_reg;

    // Counter is held while idle, so a new frame always starts on a fresh full bit period.
    fp32_uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_cnt (
        .CLK_I  (CLK_I),
        .RST_I  (RST_I),
        .clear  (state_reg == IDLE),
        .bit_end(bit_end)
    );

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_reg    <= IDLE;
            bit_idx_reg  <= '0;
            byte_idx_reg <= '0;
            stop_cnt_reg <= '0;
            data_reg     <= '0;
            line_reg     <= 1'b1;
            ready_reg    <= 1'b1;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            bit_idx_reg  <= bit_idx_next;
            byte_idx_reg <= byte_idx_next;
            stop_cnt_reg <= stop_cnt_next;
            if (accept) begin
                data_reg <= TX_DATA_I;
            end
            line_reg  <= line_next;
            ready_reg <= ready_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        bit_idx_next  = bit_idx_reg;
        byte_idx_next = byte_idx_reg;
        stop_cnt_next = stop_cnt_reg;
        frame_end     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next    = START;
                    bit_idx_next  = '0;
                    byte_idx_next = '0;
                    stop_cnt_next = '0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_next   = DATA;
                    bit_idx_next = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx_reg == 3'd7) begin
                        state_next    = STOP;
                        bit_idx_next  = '0;
                        stop_cnt_next = '0;
                    end else begin
                        bit_idx_next = bit_idx_reg + 3'd1;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (stop_cnt_reg != STOP_LAST) begin
                        stop_cnt_next = stop_cnt_reg + 1'b1;
                    end else if (byte_idx_reg != BYTE_LAST) begin
                        byte_idx_next = byte_idx_reg + 1'b1;
                        state_next    = START;
                    end else begin
                        state_next = IDLE;
                        frame_end  = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // {byte_idx, bit_idx} is byte_idx*8 + bit_idx without a multiplier.
    always_comb begin
        line_next  = 1'b1;
        ready_next = 1'b0;
        busy_next  = 1'b1;
        done_next  = frame_end;
        bit_sel    = {byte_idx_next, bit_idx_next};
        case (state_next)
            IDLE: begin
                ready_next = 1'b1;
                busy_next  = 1'b0;
            end
            START: line_next = 1'b0;
            DATA:  line_next = data_reg[bit_sel];
            STOP:  line_next = 1'b1;
            default: begin
                ready_next = 1'b1;
                busy_next  = 1'b0;
            end
        endcase
    end

    assign UART_TX_O  = line_reg;
    assign TX_READY_O = ready_reg;
    assign TX_BUSY_O  = busy_reg;
    assign TX_DONE_O  = done_reg;

endmodule

// File: tb/tb_fp32_uart_tx_96.sv
// Directed bench for fp32_uart_tx_96 at 16 clocks per bit: samples the line every cycle
// and decodes it like the 96-bit receiver would.
module tb_fp32_uart_tx_96;

    localparam int CPB   = 16;
    localparam int FRAME = 12 * 11 * CPB;
    localparam int NS    = 4600;

    logic        CLK_I = 1'b0;
    logic        RST_I;
    logic        TX_VALID_I;
    logic        TX_READY_O;
    logic [95:0] TX_DATA_I;
    logic        UART_TX_O;
    logic        TX_BUSY_O;
    logic        TX_DONE_O;

    logic line_s  [NS];
    logic done_s  [NS];
    logic ready_s [NS];
    logic busy_s  [NS];

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [95:0] W1 = 96'h3F800000_40000000_40400000;
    localparam logic [95:0] W2 = 96'h12345678_9ABCDEF0_0F1E2D3C;
    localparam logic [95:0] W3 = 96'hFFFFFFFF_00000000_AAAAAAAA;
    localparam logic [95:0] WX = 96'hDEADBEEF_CAFEF00D_55AA55AA;

    fp32_uart_tx_96 #(
        .CLKS_PER_BIT(CPB),
        .NUM_BYTES   (12),
        .STOP_BITS   (2)
    ) dut (
        .CLK_I     (CLK_I),
        .RST_I     (RST_I),
        .TX_VALID_I(TX_VALID_I),
        .TX_READY_O(TX_READY_O),
        .TX_DATA_I (TX_DATA_I),
        .UART_TX_O (UART_TX_O),
        .TX_BUSY_O (TX_BUSY_O),
        .TX_DONE_O (TX_DONE_O)
    );

    always #5 CLK_I = ~CLK_I;

    task automatic check_val(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Sample once per cycle on the falling edge; index 0 is the cycle after the accept edge.
    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK_I);
            line_s[i]  = UART_TX_O;
            done_s[i]  = TX_DONE_O;
            ready_s[i] = TX_READY_O;
            busy_s[i]  = TX_BUSY_O;
        end
    endtask

    task automatic accept_word(input logic [95:0] w, input logic hold_valid);
        @(negedge CLK_I);
        TX_DATA_I  = w;
        TX_VALID_I = 1'b1;
        @(posedge CLK_I);
        #1;
        TX_VALID_I = hold_valid;
        if (!hold_valid) TX_DATA_I = WX;
    endtask

    function automatic logic ideal_bit(input logic [95:0] w, input int b);
        int by;
        int pos;
        by  = b / 11;
        pos = b % 11;
        if (pos == 0) return 1'b0;
        if (pos <= 8) return w[by*8 + pos - 1];
        return 1'b1;
    endfunction

    function automatic logic [95:0] decode(input int off);
        logic [95:0] w;
        w = '0;
        for (int k = 0; k < 12; k++)
            for (int j = 0; j < 8; j++)
                w[k*8 + j] = line_s[off + (k*11 + 1 + j)*CPB + CPB/2];
        return w;
    endfunction

    function automatic int wave_errors(input int off, input logic [95:0] w);
        int e;
        e = 0;
        for (int i = 0; i < FRAME; i++)
            if (line_s[off + i] !== ideal_bit(w, i / CPB)) e++;
        return e;
    endfunction

    function automatic int first_done(input int n);
        for (int i = 0; i < n; i++)
            if (done_s[i] === 1'b1) return i;
        return -1;
    endfunction

    function automatic int count_done(input int n);
        int c;
        c = 0;
        for (int i = 0; i < n; i++)
            if (done_s[i] === 1'b1) c++;
        return c;
    endfunction

    function automatic int count_ready(input int n);
        int c;
        c = 0;
        for (int i = 0; i < n; i++)
            if (ready_s[i] === 1'b1) c++;
        return c;
    endfunction

    initial begin
        logic [95:0] got;
        RST_I      = 1'b1;
        TX_VALID_I = 1'b0;
        TX_DATA_I  = '0;

        // Reset state, held with no valid
        repeat (3) @(negedge CLK_I);
        check_val("rst_line", 96'(UART_TX_O), 96'd1);
        check_val("rst_ready", 96'(TX_READY_O), 96'd1);
        check_val("rst_busy", 96'(TX_BUSY_O), 96'd0);
        check_val("rst_done", 96'(TX_DONE_O), 96'd0);
        RST_I = 1'b0;
        capture(40);
        check_val("idle_line_low_cycles", 96'(40 - count_ready(40)), 96'd0);
        check_val("idle_done_cnt", 96'(count_done(40)), 96'd0);
        check_val("idle_line", 96'(line_s[39]), 96'd1);

        // Word 1: wire bytes 00 00 40 40 00 00 00 40 00 00 80 3F
        accept_word(W1, 1'b0);
        capture(FRAME + 8);
        got = decode(0);
        $display("tx word %h -> wire %h", W1, got);
        check_val("w1_data", got, W1);
        check_val("w1_byte2", 96'(got[23:16]), 96'h40);
        check_val("w1_byte11", 96'(got[95:88]), 96'h3F);
        check_val("w1_first_fall", 96'(line_s[0]), 96'd0);
        check_val("w1_busy", 96'(busy_s[0]), 96'd1);
        check_val("w1_wave_errs", 96'(wave_errors(0, W1)), 96'd0);
        check_val("w1_done_at", 96'(first_done(FRAME + 8)), 96'(FRAME));
        check_val("w1_done_cnt", 96'(count_done(FRAME + 8)), 96'd1);
        check_val("w1_ready_at_done", 96'(ready_s[FRAME]), 96'd1);
        check_val("w1_busy_at_done", 96'(busy_s[FRAME]), 96'd0);

        // Word 2 with a foreign valid pulse mid-frame
        accept_word(W2, 1'b0);
        fork
            capture(FRAME + 8);
            begin
                repeat (300) @(negedge CLK_I);
                TX_DATA_I  = WX;
                TX_VALID_I = 1'b1;
                repeat (3) @(negedge CLK_I);
                TX_VALID_I = 1'b0;
            end
        join
        got = decode(0);
        $display("tx word %h -> wire %h", W2, got);
        check_val("w2_data", got, W2);
        check_val("w2_wave_errs", 96'(wave_errors(0, W2)), 96'd0);
        check_val("w2_ready_in_frame", 96'(count_ready(FRAME)), 96'd0);
        check_val("w2_done_at", 96'(first_done(FRAME + 8)), 96'(FRAME));

        // Reset during the start bit of byte 5
        accept_word(W1, 1'b0);
        capture(5*11*CPB + 5);
        check_val("b5_start_low", 96'(line_s[5*11*CPB + 4]), 96'd0);
        RST_I = 1'b1;
        #1;
        check_val("rst_mid_line", 96'(UART_TX_O), 96'd1);
        check_val("rst_mid_ready", 96'(TX_READY_O), 96'd1);
        check_val("rst_mid_busy", 96'(TX_BUSY_O), 96'd0);
        repeat (2) @(negedge CLK_I);
        RST_I = 1'b0;
        capture(FRAME + 8);
        check_val("rst_mid_no_done", 96'(count_done(FRAME + 8)), 96'd0);
        check_val("rst_mid_line_idle", 96'(count_ready(FRAME + 8)), 96'(FRAME + 8));
        $display("tx word %h aborted by reset in byte 5", W1);

        accept_word(W3, 1'b0);
        capture(FRAME + 8);
        got = decode(0);
        $display("tx word %h -> wire %h", W3, got);
        check_val("w3_data", got, W3);
        check_val("w3_wave_errs", 96'(wave_errors(0, W3)), 96'd0);
        check_val("w3_done_at", 96'(first_done(FRAME + 8)), 96'(FRAME));

        // Back-to-back: valid held high, second word taken on the done cycle
        accept_word(W2, 1'b1);
        TX_DATA_I = W3;
        capture(2*FRAME + 12);
        TX_VALID_I = 1'b0;
        got = decode(0);
        $display("tx word %h -> wire %h (b2b first)", W2, got);
        check_val("b2b_first", got, W2);
        check_val("b2b_done1", 96'(first_done(FRAME + 1)), 96'(FRAME));
        check_val("b2b_next_start", 96'(line_s[FRAME + 1]), 96'd0);
        got = decode(FRAME + 1);
        $display("tx word %h -> wire %h (b2b second)", W3, got);
        check_val("b2b_second", got, W3);
        check_val("b2b_wave2_errs", 96'(wave_errors(FRAME + 1, W3)), 96'd0);
        check_val("b2b_done_cnt", 96'(count_done(2*FRAME + 12)), 96'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
